hack_seq_ctrl: RTL
==================

Name: hack_seq_ctrl

Overview:
- Multi-cycle control sequencer for the Hack CPU.
- Fetches each instruction from instruction ROM over a req/ack handshake and latches it into an instruction register (ir). The ir feeds the instruction decoder and the datapath.
- Sequences the data-memory read/write and evaluates the jump condition from the ALU flags.
- Issues a single commit strobe set per instruction (register loads, PC update) and counts retired instructions.

Parameters:
- DW, 16, instruction/data width; ir[DW-1] is the A/C type bit.
- CW, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute instructions, 0 = stop after the current instruction.
- rom_req  out  1  instruction fetch request.
- rom_ack  in  1  fetch acknowledge; rom_data is valid in the same cycle.
- rom_data  in  DW  fetched instruction.
- ir  out  DW  latched instruction, to the decoder.
- dm_req  out  1  data-memory request.
- dm_we  out  1  1 = write, 0 = read; valid while dm_req=1.
- dm_ack  in  1  data-memory acknowledge (read data valid / write done).
- zr  in  1  ALU zero flag.
- ng  in  1  ALU negative flag.
- load_a  out  1  A register load strobe.
- a_src  out  1  A input select: 0 = ir value field, 1 = ALU out.
- load_d  out  1  D register load strobe.
- pc_load  out  1  PC loads A.
- pc_inc  out  1  PC increments.
- busy  out  1  state != IDLE.
- instr_cnt  out  CW  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ir=0, instr_cnt=0.
  - All strobes, rom_req, dm_req, dm_we and busy = 0, immediately and without waiting for a clock edge.
  - An outstanding handshake is abandoned; no commit occurs.
- Instruction fields taken from ir:
  - type = ir[DW-1], a = ir[12], d1/d2/d3 = ir[5]/ir[4]/ir[3], j1/j2/j3 = ir[2]/ir[1]/ir[0].
- States (registered FSM):
  - IDLE: all outputs 0. run=1 -> FETCH.
  - FETCH: rom_req=1 held until rom_ack. On the ack cycle, ir <= rom_data -> DECODE. Ack in the first FETCH cycle is legal.
  - DECODE: 1 cycle.
    - type=0 -> EXEC.
    - type=1 and a=1 -> MEM_RD.
    - type=1 and a=0 -> EXEC.
  - MEM_RD: dm_req=1, dm_we=0, held until dm_ack -> EXEC. The datapath latches M on the ack edge.
  - EXEC: 1 cycle.
    - type=0: commit.
    - type=1, d3=0: commit.
    - type=1, d3=1: no strobes -> MEM_WR.
  - MEM_WR: dm_req=1, dm_we=1, held until dm_ack. Commit in the ack cycle.
- Commit (exactly one cycle per instruction):
  - type=0: load_a=1, a_src=0, pc_inc=1.
  - type=1: load_a=d1, a_src=1, load_d=d2.
    - jump = (j1&ng) | (j2&zr) | (j3&~ng&~zr); zr and ng are sampled in the commit cycle.
    - pc_load=jump, pc_inc=~jump.
  - instr_cnt <= instr_cnt+1, wrapping from 2^CW-1 to 0.
  - Next state: run=1 -> FETCH, else IDLE.
- Invariants:
  - No register load occurs before the M write completes, so the M address and the jump target are the pre-instruction A, and ALU inputs stay stable through MEM_WR.
  - pc_load and pc_inc are mutually exclusive.
  - Strobes are never asserted outside the commit cycle.
  - rom_req and dm_req are never high together.
- run deasserted mid-instruction: the instruction completes, then the FSM goes to IDLE. run is sampled only in IDLE and at commit.
- Ack inputs asserted while not requesting are ignored.
- Minimum latency:
  - A-instruction: 3 cycles (FETCH, DECODE, EXEC).
  - C-instruction with M read: 4 cycles.
  - C-instruction with M write: 4 cycles.
  - Each extra wait cycle on rom_ack or dm_ack adds 1.

Test Plan:
1. run=1; rom_ack in first FETCH cycle with rom_data=0x0005 -> ir=0x0005. Third cycle: load_a=1, a_src=0, pc_inc=1. instr_cnt=1. Back in FETCH.
2. rom_data=0xFC10 (D=M); dm_ack delayed 3 cycles -> dm_req=1, dm_we=0 for 4 cycles. Then EXEC: load_d=1, load_a=0, pc_inc=1.
3. rom_data=0xE308 (M=D) -> EXEC has no strobes. MEM_WR: dm_we=1 held until ack. Ack cycle: pc_inc=1, load_a=0, load_d=0, instr_cnt increments.
4. 0xE304 (D;JLT): ng=1, zr=0 -> pc_load=1, pc_inc=0. ng=0, zr=0 -> pc_inc=1. 0xEA87 (0;JMP) with any flags -> pc_load=1.
5. rst_n=0 while in FETCH waiting with rom_req=1 -> rom_req=0 and busy=0 before the next edge. instr_cnt=0, ir=0. After release with run=1, fetch restarts.
6. CW=4, 16 A-instructions -> instr_cnt wraps to 0. Drop run during the 17th DECODE -> that instruction commits, instr_cnt=1, then IDLE with busy=0.

Source files
------------

// File: rtl/hack_seq_ctrl.sv
// Multi-cycle control sequencer for the Hack CPU: fetch over a ROM handshake,
// optional data-memory read/write, jump evaluation and one commit per instruction.
module hack_seq_ctrl #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          rom_req,
  input  logic          rom_ack,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] ir,
  output logic          dm_req,
  output logic          dm_we,
  input  logic          dm_ack,
  input  logic          zr,
  input  logic          ng,
  output logic          load_a,
  output logic          a_src,
  output logic          load_d,
  output logic          pc_load,
  output logic          pc_inc,
  output logic          busy,
  output logic [CW-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM_RD = 3'd3,
    EXEC   = 3'd4,
    MEM_WR = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic i_type, i_a, i_d1, i_d2, i_d3, i_j1, i_j2, i_j3;
  logic jump;
  logic commit;

  // Instruction fields and jump condition decoded from the latched ir
  assign i_type = ir_q[DW-1];
  assign i_a    = ir_q[12];
  assign i_d1   = ir_q[5];
  assign i_d2   = ir_q[4];
  assign i_d3   = ir_q[3];
  assign i_j1   = ir_q[2];
  assign i_j2   = ir_q[1];
  assign i_j3   = ir_q[0];
  assign jump   = (i_j1 & ng) | (i_j2 & zr) | (i_j3 & ~ng & ~zr);

  assign ir        = ir_q;
  assign instr_cnt = cnt_q;

  // State, instruction and retire-count registers; reset abandons any handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and state-decoded outputs; strobes only in the commit cycle
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    rom_req = 1'b0;
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    commit  = 1'b0;
    load_a  = 1'b0;
    a_src   = 1'b0;
    load_d  = 1'b0;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    busy    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        rom_req = 1'b1;
        if (rom_ack) begin
          ir_d    = rom_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = (i_type && i_a) ? MEM_RD : EXEC;
      end
      MEM_RD: begin
        dm_req = 1'b1;
        if (dm_ack) state_d = EXEC;
      end
      EXEC: begin
        // A memory write must finish before any register or PC update
        if (i_type && i_d3) state_d = MEM_WR;
        else                commit  = 1'b1;
      end
      MEM_WR: begin
        dm_req = 1'b1;
        dm_we  = 1'b1;
        if (dm_ack) commit = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      if (!i_type) begin
        load_a = 1'b1;
        pc_inc = 1'b1;
      end else begin
        load_a  = i_d1;
        a_src   = 1'b1;
        load_d  = i_d2;
        pc_load = jump;
        pc_inc  = ~jump;
      end
      cnt_d   = cnt_q + 1'b1;
      state_d = run ? FETCH : IDLE;
    end
  end

endmodule
